// File: rtl/xcvr_clkout2_freq_monitor_if.sv
// -----------------------------------------------------------------------------
// xcvr_clkout2_freq_monitor_if
//
// Host-side control/status bundle of the clkout2 frequency monitor.
//
// Optional feature macro: XCVR_CLKMON_STICKY_EN (adds fault_clr, ch_fault, irq).
//
// Signals (direction seen from the monitor, i.e. the slave modport):
//   ch_en      in   N_CH   channel enables, sampled at sweep start
//   window     in   WIN_W  measurement length in clk cycles, sampled at start
//   thr_lo     in   CNT_W  minimum passing edge count (inclusive, live)
//   thr_hi     in   CNT_W  maximum passing edge count (inclusive, live)
//   start      in   1      single-sweep request
//   continuous in   1      level, back-to-back sweeps while high
//   busy       out  1      monitor is not in IDLE
//   sweep_done out  1      one-cycle pulse at end of a sweep
//   rd_sel     in   SEL_W  readback channel select
//   rd_count   out  CNT_W  stored count of channel rd_sel (combinational)
//   ch_ok      out  N_CH   per-channel pass flags
//   fault_clr  in   1      clears sticky faults            (macro only)
//   ch_fault   out  N_CH   sticky per-channel fault flags  (macro only)
//   irq        out  1      registered OR of ch_fault       (macro only)
//
// Handshake: there is no ready signal. start (or continuous) acts as a valid
// that is consumed only in a cycle where busy is low and the qualifiers hold
// (ch_en != 0, window != 0); in any other cycle the request is dropped, not
// queued. busy therefore doubles as the inverted ready. sweep_done is a
// single-cycle completion strobe with no acknowledge.
// -----------------------------------------------------------------------------
interface xcvr_clkout2_freq_monitor_if #(
  parameter int N_CH  = 4,
  parameter int WIN_W = 16,
  parameter int CNT_W = 16,
  parameter int SEL_W = 2
);
  logic [N_CH-1:0]  ch_en;
  logic [WIN_W-1:0] window;
  logic [CNT_W-1:0] thr_lo;
  logic [CNT_W-1:0] thr_hi;
  logic             start;
  logic             continuous;
  logic             busy;
  logic             sweep_done;
  logic [SEL_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_count;
  logic [N_CH-1:0]  ch_ok;
`ifdef XCVR_CLKMON_STICKY_EN
  logic             fault_clr;
  logic [N_CH-1:0]  ch_fault;
  logic             irq;

  modport master (
    output ch_en, window, thr_lo, thr_hi, start, continuous, rd_sel, fault_clr,
    input  busy, sweep_done, rd_count, ch_ok, ch_fault, irq
  );
  modport slave (
    input  ch_en, window, thr_lo, thr_hi, start, continuous, rd_sel, fault_clr,
    output busy, sweep_done, rd_count, ch_ok, ch_fault, irq
  );
`else
  modport master (
    output ch_en, window, thr_lo, thr_hi, start, continuous, rd_sel,
    input  busy, sweep_done, rd_count, ch_ok
  );
  modport slave (
    input  ch_en, window, thr_lo, thr_hi, start, continuous, rd_sel,
    output busy, sweep_done, rd_count, ch_ok
  );
`endif
endinterface

// File: rtl/xcvr_clkout2_freq_monitor.sv
// -----------------------------------------------------------------------------
// xcvr_clkout2_freq_monitor
//
// Time-shared frequency monitor for the transceiver clkout2 fan-out. Each
// monitored clock arrives as a divided toggle signal, asynchronous to clk.
// A single edge counter is swept round-robin over the enabled channels; each
// channel is measured for `window` clk cycles, its count is stored and
// compared against [thr_lo, thr_hi], and the result is kept per channel.
//
// Optional feature macro: XCVR_CLKMON_STICKY_EN
//   Adds sticky per-channel fault flags (set by a failing check, cleared by
//   fault_clr, set wins) and a registered interrupt (OR of the faults).
//
// Ports:
//   clk        in   1      management clock, all logic on posedge
//   reset_n    in   1      asynchronous active-low reset
//   ch_toggle  in   N_CH   divided clocks, asynchronous to clk
//   host       slave modport of xcvr_clkout2_freq_monitor_if (control/status)
//   dbg_state  out  2      current FSM state (0 IDLE, 1 MEASURE, 2 CHECK,
//                          3 NEXT) for debug and checkers
//
// Sweep timing with W = latched window and K enabled channels, start sampled
// in IDLE during cycle 0: MEASURE occupies W cycles per channel, followed by
// one CHECK and one NEXT cycle; sweep_done is high in cycle K*(W+2) and busy
// is high in cycles 1 .. K*(W+2).
// -----------------------------------------------------------------------------
module xcvr_clkout2_freq_monitor #(
  parameter int N_CH  = 4,
  parameter int WIN_W = 16,
  parameter int CNT_W = 16,
  parameter int SEL_W = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_CH-1:0]              ch_toggle,
  xcvr_clkout2_freq_monitor_if.slave   host,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_CHECK   = 2'd2,
    S_NEXT    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Index of the lowest set bit (0 when none is set; callers guard that case).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] v);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) res = SEL_W'(i);
    end
    return res;
  endfunction

  // Mask of channel positions strictly above cur.
  function automatic logic [N_CH-1:0] above_mask(input logic [SEL_W-1:0] cur);
    logic [N_CH-1:0] res;
    for (int i = 0; i < N_CH; i++) begin
      res[i] = (i > int'(cur));
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0]             sync1_q, sync1_d;
  logic [N_CH-1:0]             sync2_q, sync2_d;
  logic [N_CH-1:0]             sync3_q, sync3_d;

  state_t                      state_q, state_d;
  logic [SEL_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [WIN_W-1:0]            timer_q, timer_d;
  logic [N_CH-1:0]             en_q, en_d;
  logic [WIN_W-1:0]            win_q, win_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [N_CH-1:0]             ok_q, ok_d;
  logic [N_CH-1:0][CNT_W-1:0]  counts_q, counts_d;

`ifdef XCVR_CLKMON_STICKY_EN
  logic [N_CH-1:0]             fault_q, fault_d;
  logic                        irq_q, irq_d;
  logic [N_CH-1:0]             fault_set;
`endif

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0]  edge_vec;
  logic             cur_edge;
  logic             start_ok;
  logic [N_CH-1:0]  higher_en;
  logic             has_next;
  logic [SEL_W-1:0] next_idx;
  logic             pass;
  logic [CNT_W-1:0] rd_mux;

  // Both toggle edges count: stage2 differs from stage3 for exactly one cycle
  // after each synchronized transition.
  assign edge_vec = sync2_q ^ sync3_q;

  always_comb begin
    cur_edge = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == SEL_W'(i)) cur_edge = edge_vec[i];
    end
  end

  assign start_ok  = (host.start | host.continuous) &&
                     (host.ch_en != '0) && (host.window != '0);
  assign higher_en = en_q & above_mask(idx_q);
  assign has_next  = (higher_en != '0);
  assign next_idx  = lowest_set(higher_en);

  // Thresholds are used live; an inverted pair can never be satisfied.
  assign pass = (host.thr_lo <= cnt_q) && (cnt_q <= host.thr_hi);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (host.rd_sel == SEL_W'(i)) rd_mux = counts_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d  = ch_toggle;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;

    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    en_d     = en_q;
    win_d    = win_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    counts_d = counts_q;
`ifdef XCVR_CLKMON_STICKY_EN
    fault_set = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          en_d    = host.ch_en;
          win_d   = host.window;
          idx_d   = lowest_set(host.ch_en);
          cnt_d   = '0;
          timer_d = host.window;
          // Results of channels left out of this sweep are no longer valid.
          ok_d    = ok_q & host.ch_en;
          busy_d  = 1'b1;
          state_d = S_MEASURE;
        end
      end

      S_MEASURE: begin
        if (cur_edge && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        timer_d = timer_q - WIN_W'(1);
        // The edge seen in the timer==1 cycle is still part of this window.
        if (timer_q == WIN_W'(1)) state_d = S_CHECK;
      end

      S_CHECK: begin
        for (int i = 0; i < N_CH; i++) begin
          if (idx_q == SEL_W'(i)) begin
            counts_d[i] = cnt_q;
            ok_d[i]     = pass;
`ifdef XCVR_CLKMON_STICKY_EN
            fault_set[i] = ~pass;
`endif
          end
        end
        // sweep_done is registered so it is high during the final NEXT cycle.
        done_d  = ~has_next;
        state_d = S_NEXT;
      end

      S_NEXT: begin
        if (has_next) begin
          idx_d   = next_idx;
          cnt_d   = '0;
          timer_d = win_q;
          state_d = S_MEASURE;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef XCVR_CLKMON_STICKY_EN
  // Set wins over a simultaneous clear; irq lags ch_fault by one cycle.
  assign fault_d = (fault_q & ~{N_CH{host.fault_clr}}) | fault_set;
  assign irq_d   = |fault_q;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      en_q     <= '0;
      win_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= '0;
      counts_q <= '0;
`ifdef XCVR_CLKMON_STICKY_EN
      fault_q  <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      en_q     <= en_d;
      win_q    <= win_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      counts_q <= counts_d;
`ifdef XCVR_CLKMON_STICKY_EN
      fault_q  <= fault_d;
      irq_q    <= irq_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign host.busy       = busy_q;
  assign host.sweep_done = done_q;
  assign host.ch_ok      = ok_q;
  assign host.rd_count   = rd_mux;
  assign dbg_state       = state_q;
`ifdef XCVR_CLKMON_STICKY_EN
  assign host.ch_fault   = fault_q;
  assign host.irq        = irq_q;
`endif

endmodule

// File: tb/tb_xcvr_clkout2_freq_monitor.sv
// -----------------------------------------------------------------------------
// tb_xcvr_clkout2_freq_monitor
//
// Self-checking bench for xcvr_clkout2_freq_monitor. Expected counts come from
// the toggle rate (one edge every hp clk cycles -> about W/hp edges per
// window, +-1 for sampling phase); sweep timing comes from K*(W+2).
// A second instance with CNT_W=4 covers counter saturation.
// Sticky-fault checks are compiled in with XCVR_CLKMON_STICKY_EN.
// -----------------------------------------------------------------------------
module tb_xcvr_clkout2_freq_monitor;
  localparam int N_CH  = 4;
  localparam int WIN_W = 16;
  localparam int CNT_W = 16;
  localparam int SEL_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic [N_CH-1:0] ch_toggle = '0;
  logic [1:0]      dbg_state;
  logic [3:0]      sat_toggle = '0;
  logic [1:0]      sat_dbg;

  xcvr_clkout2_freq_monitor_if #(.N_CH(N_CH), .WIN_W(WIN_W), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();
  xcvr_clkout2_freq_monitor_if #(.N_CH(4), .WIN_W(16), .CNT_W(4), .SEL_W(2)) sbus ();

  xcvr_clkout2_freq_monitor #(.N_CH(N_CH), .WIN_W(WIN_W), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset_n(reset_n), .ch_toggle(ch_toggle), .host(bus), .dbg_state(dbg_state)
  );

  xcvr_clkout2_freq_monitor #(.N_CH(4), .WIN_W(16), .CNT_W(4), .SEL_W(2)) sat (
    .clk(clk), .reset_n(reset_n), .ch_toggle(sat_toggle), .host(sbus), .dbg_state(sat_dbg)
  );

  // ---------------- toggle sources ----------------
  // hp[c] = clk cycles between toggle edges on channel c (0 = static).
  int hp[N_CH];
  int tc[N_CH];
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N_CH; i++) begin
      if (hp[i] > 0) begin
        tc[i] = tc[i] + 1;
        if (tc[i] >= hp[i]) begin
          tc[i] = 0;
          ch_toggle[i] = ~ch_toggle[i];
        end
      end
    end
    sat_toggle = ~sat_toggle;
  end

  // ---------------- scoreboard / monitor ----------------
  int checks = 0;
  int errors = 0;
  int base = 0;
  int done_cnt = 0;
  int last_done = -1;
  int rise_cyc = -1;
  int fall_cyc = -1;
  logic busy_prev = 1'b0;
  int done_hist[$];

  always @(negedge clk) begin
    if (bus.sweep_done) begin
      done_cnt = done_cnt + 1;
      last_done = cyc - base;
      done_hist.push_back(cyc - base);
    end
    if (bus.busy && !busy_prev) rise_cyc = cyc - base;
    if (!bus.busy && busy_prev) fall_cyc = cyc - base;
    busy_prev = bus.busy;
  end

  task automatic check(input string tag, input longint obs, input longint exp, input int tol = 0);
    longint d;
    checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // start is high during cycle 0; cycle k then has cyc == base + k.
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    base = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n0;
    int k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == n0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic rd(input int sel, output longint v);
    bus.rd_sel = SEL_W'(sel);
    #1;
    v = bus.rd_count;
  endtask

  task automatic setup(input logic [3:0] en, input int w, input int lo, input int hi);
    bus.ch_en  = en;
    bus.window = WIN_W'(w);
    bus.thr_lo = CNT_W'(lo);
    bus.thr_hi = CNT_W'(hi);
  endtask

  task automatic run_sweep(input logic [3:0] en, input int w, input string tag);
    pulse_start();
    wait_done($countones(en) * (w + 2) + 20, tag);
    tick(2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    longint v;
    int n0;
    int k;
    logic busy_seen;
    logic seen;

    for (int i = 0; i < N_CH; i++) begin
      hp[i] = 0;
      tc[i] = 0;
    end
    setup(4'b0000, 0, 0, 0);
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.rd_sel = '0;
    sbus.ch_en = '0;
    sbus.window = '0;
    sbus.thr_lo = '0;
    sbus.thr_hi = '0;
    sbus.start = 1'b0;
    sbus.continuous = 1'b0;
    sbus.rd_sel = '0;
`ifdef XCVR_CLKMON_STICKY_EN
    bus.fault_clr = 1'b0;
    sbus.fault_clr = 1'b0;
`endif

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.sweep_done, 0);
    check("rst_ok", bus.ch_ok, 0);
    for (int s = 0; s < N_CH; s++) begin
      rd(s, v);
      check($sformatf("rst_cnt%0d", s), v, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    // Single channel: 25 edges in 100 cycles
    hp[0] = 4;
    tick(20);
    setup(4'b0001, 100, 24, 26);
    run_sweep(4'b0001, 100, "t1");
    rd(0, v);
    check("t1_count", v, 25, 1);
    check("t1_ok", bus.ch_ok[0], 1);
    check("t1_done_cyc", last_done, 102);
    check("t1_busy_rise", rise_cyc, 1);
    check("t1_busy_fall", fall_cyc, 103);

    // Channel 2 alone, so its ok flag is set before the multi sweep skips it
    hp[0] = 2; hp[1] = 5; hp[2] = 5; hp[3] = 10;
    tick(30);
    setup(4'b0100, 50, 4, 26);
    run_sweep(4'b0100, 50, "t2a");
    rd(2, v);
    check("t2a_count2", v, 10, 1);
    check("t2a_ok2", bus.ch_ok[2], 1);

    // Multi-channel, ch2 skipped
    setup(4'b1011, 50, 4, 26);
    run_sweep(4'b1011, 50, "t2");
    rd(0, v); check("t2_count0", v, 25, 1);
    rd(1, v); check("t2_count1", v, 10, 1);
    rd(3, v); check("t2_count3", v, 5, 1);
    check("t2_ok", bus.ch_ok, 4'b1011);
    check("t2_done_cyc", last_done, 156);

    // Dead clock
    hp[1] = 0;
    tick(20);
    setup(4'b0010, 60, 1, 100);
    run_sweep(4'b0010, 60, "t3");
    rd(1, v);
    check("t3_dead_count", v, 0);
    check("t3_dead_ok", bus.ch_ok[1], 0);

    // Inverted thresholds always fail
    setup(4'b0001, 40, 30, 10);
    run_sweep(4'b0001, 40, "t4");
    rd(0, v);
    check("t4_count", v, 20, 1);
    check("t4_inv_ok", bus.ch_ok[0], 0);

    // Saturation on the CNT_W=4 instance
    sbus.ch_en = 4'b0001;
    sbus.window = 16'd40;
    sbus.thr_lo = 4'd0;
    sbus.thr_hi = 4'd15;
    @(negedge clk);
    sbus.start = 1'b1;
    @(negedge clk);
    sbus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sbus.sweep_done) seen = 1'b1;
    end
    check("sat_done_seen", seen, 1);
    sbus.rd_sel = 2'd0;
    #1;
    check("sat_count", sbus.rd_count, 15);
    check("sat_ok", sbus.ch_ok[0], 1);
    check("sat_idle", sat_dbg, 0);

    // Start qualifiers: window = 0, then ch_en = 0
    setup(4'b0001, 0, 0, 100);
    n0 = done_cnt;
    pulse_start();
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.busy;
    end
    check("q_win0_done", done_cnt - n0, 0);
    check("q_win0_busy", busy_seen, 0);
    setup(4'b0000, 50, 0, 100);
    pulse_start();
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.busy;
    end
    check("q_en0_done", done_cnt - n0, 0);
    check("q_en0_busy", busy_seen, 0);

    // Start while busy is ignored
    setup(4'b0001, 30, 10, 20);
    n0 = done_cnt;
    pulse_start();
    tick(10);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(80);
    check("busy_start_done_cnt", done_cnt - n0, 1);
    check("busy_start_done_cyc", last_done, 32);

    // Continuous mode: period K*(W+2)+1
    setup(4'b0011, 10, 4, 6);
    done_hist.delete();
    @(negedge clk);
    bus.continuous = 1'b1;
    base = cyc;
    k = 0;
    while (done_hist.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    bus.continuous = 1'b0;
    if (done_hist.size() < 3) begin
      check("cont_timeout", done_hist.size(), 3);
    end else begin
      check("cont_first", done_hist[0], 24);
      check("cont_period1", done_hist[1] - done_hist[0], 25);
      check("cont_period2", done_hist[2] - done_hist[1], 25);
    end
    k = 0;
    while (bus.busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("cont_stops", bus.busy, 0);
    tick(2);
    check("cont_ok", bus.ch_ok, 4'b0001);

    // Reset in the middle of MEASURE, then restart
    hp[0] = 4;
    tick(20);
    setup(4'b0001, 100, 24, 26);
    pulse_start();
    tick(10);
    check("mid_state_measure", dbg_state, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.sweep_done, 0);
    check("mid_rst_ok", bus.ch_ok, 0);
    check("mid_rst_state", dbg_state, 0);
    for (int s = 0; s < N_CH; s++) begin
      rd(s, v);
      check($sformatf("mid_rst_cnt%0d", s), v, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(3);
    run_sweep(4'b0001, 100, "restart");
    rd(0, v);
    check("restart_count", v, 25, 1);
    check("restart_ok", bus.ch_ok[0], 1);
    check("restart_done_cyc", last_done, 102);

    // Randomized sweeps against the rate model
    for (int it = 0; it < 8; it++) begin
      int w, kk, lo, hi, nom, fl, ce, lb, ub;
      logic [3:0] en;
      en = 4'($urandom_range(1, 15));
      w  = $urandom_range(20, 150);
      for (int c = 0; c < N_CH; c++) hp[c] = $urandom_range(2, 12);
      lo = $urandom_range(0, 30);
      hi = lo + $urandom_range(0, 40) - 5;
      if (hi < 0) hi = 0;
      setup(en, w, lo, hi);
      tick(30);
      kk = $countones(en);
      run_sweep(en, w, "rnd");
      check($sformatf("rnd%0d_done_cyc", it), last_done, kk * (w + 2));
      for (int c = 0; c < N_CH; c++) begin
        if (en[c]) begin
          rd(c, v);
          nom = (w + hp[c] / 2) / hp[c];
          fl  = w / hp[c];
          ce  = (w + hp[c] - 1) / hp[c];
          lb  = (fl > 0) ? fl - 1 : 0;
          ub  = ce + 1;
          check($sformatf("rnd%0d_cnt%0d", it, c), v, nom, 1);
          if (lo > hi || ub < lo || lb > hi)
            check($sformatf("rnd%0d_ok%0d", it, c), bus.ch_ok[c], 0);
          else if (lo <= lb && ub <= hi)
            check($sformatf("rnd%0d_ok%0d", it, c), bus.ch_ok[c], 1);
        end else begin
          check($sformatf("rnd%0d_okdis%0d", it, c), bus.ch_ok[c], 0);
        end
      end
    end

`ifdef XCVR_CLKMON_STICKY_EN
    begin
      int fault_cyc, irq_cyc;
      hp[0] = 2;
      tick(30);
      // Failing sweep: CHECK in cycle 41, fault visible 42, irq 43
      setup(4'b0001, 40, 50, 60);
      bus.fault_clr = 1'b1;
      tick(1);
      bus.fault_clr = 1'b0;
      tick(2);
      check("stk_pre_clear", bus.ch_fault, 0);
      fault_cyc = -1;
      irq_cyc = -1;
      pulse_start();
      for (int i = 0; i < 60; i++) begin
        if (bus.ch_fault[0] && fault_cyc < 0) fault_cyc = cyc - base;
        if (bus.irq && irq_cyc < 0) irq_cyc = cyc - base;
        @(negedge clk);
      end
      check("stk_fault_cyc", fault_cyc, 42);
      check("stk_irq_cyc", irq_cyc, 43);
      // Passing sweep keeps the sticky state
      setup(4'b0001, 40, 19, 21);
      run_sweep(4'b0001, 40, "stk_pass");
      check("stk_pass_ok", bus.ch_ok[0], 1);
      check("stk_persist_fault", bus.ch_fault[0], 1);
      check("stk_persist_irq", bus.irq, 1);
      // Clear
      bus.fault_clr = 1'b1;
      tick(1);
      bus.fault_clr = 1'b0;
      tick(2);
      check("stk_clr_fault", bus.ch_fault, 0);
      check("stk_clr_irq", bus.irq, 0);
      // Clear in the same cycle as a failing CHECK: set wins
      setup(4'b0001, 40, 50, 60);
      pulse_start();
      tick(40);
      check("stk_in_check", dbg_state, 2);
      bus.fault_clr = 1'b1;
      tick(1);
      bus.fault_clr = 1'b0;
      tick(3);
      check("stk_setwins_fault", bus.ch_fault[0], 1);
      check("stk_setwins_irq", bus.irq, 1);
    end
`endif

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcvr_clkout2_freq_monitor.md
# xcvr_clkout2_freq_monitor

Time-shared frequency monitor for the transceiver `clkout2` fan-out (TX and RX copies). Each monitored clock is divided in its own domain into a toggle signal and fed in asynchronously. The block runs in the management clock domain. It sequences one shared edge counter across the enabled channels in a round-robin sweep, checks each count against a pass window, and exposes per-channel status and count readback to the test-system host.

## Interface
Parameters:
- `N_CH`, 4, number of monitored toggle channels (2..8).
- `WIN_W`, 16, width of the measurement-window length in clk cycles.
- `CNT_W`, 16, width of the edge counter and thresholds.
- `SEL_W`, 2, readback select width; equals ceil(log2(N_CH)).

Ports:
- `clk`  in  1  management clock; all logic is on this edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `ch_toggle`  in  N_CH  divided clocks, asynchronous to clk.
- `ch_en`  in  N_CH  channel enables, sampled at sweep start.
- `window`  in  WIN_W  measurement length in clk cycles, sampled at sweep start.
- `thr_lo`  in  CNT_W  minimum passing edge count, inclusive.
- `thr_hi`  in  CNT_W  maximum passing edge count, inclusive.
- `start`  in  1  one-cycle request for a single sweep.
- `continuous`  in  1  level; while high, sweeps restart back-to-back.
- `busy`  out  1  high in every state except IDLE.
- `sweep_done`  out  1  one-cycle pulse when a sweep ends.
- `rd_sel`  in  SEL_W  selects the channel for `rd_count`.
- `rd_count`  out  CNT_W  last stored count of channel `rd_sel`, combinational mux.
- `ch_ok`  out  N_CH  per-channel pass flags.
- `fault_clr`  in  1  clears sticky faults. Present only with the macro.
- `ch_fault`  out  N_CH  sticky fault flags. Present only with the macro.
- `irq`  out  1  OR of `ch_fault`, registered. Present only with the macro.

## Operation
- Synchronizer: each `ch_toggle` bit passes through two flops, then a third flop for edge detection. Edge = stage2 XOR stage3, so both toggle edges count. All channels are synchronized continuously.
- FSM has four states: IDLE, MEASURE, CHECK, NEXT.
- IDLE:
  - Sweep starts on (`start` | `continuous`) & (`ch_en` != 0) & (`window` != 0).
  - At sweep start: latch `ch_en` and `window`, set idx to the lowest enabled channel, clear the counter, load timer = `window`, clear `ch_ok` bits of disabled channels, go to MEASURE.
  - Any other condition stays in IDLE. `start` is ignored when not in IDLE.
- MEASURE:
  - Each cycle, an edge on channel idx increments the counter. The counter saturates at 2^CNT_W-1.
  - Timer decrements each cycle. In the cycle with timer == 1 (that cycle's edge still counts), go to CHECK.
- CHECK (1 cycle): store the counter into count[idx]; set `ch_ok[idx]` = (`thr_lo` <= count <= `thr_hi`). Thresholds are used live, not latched.
- NEXT (1 cycle):
  - If a higher enabled channel exists, set idx to it, clear the counter, reload timer, go to MEASURE.
  - Otherwise pulse `sweep_done` and go to IDLE.
- Continuous mode re-evaluates the start condition in IDLE, so consecutive sweeps are separated by one IDLE cycle.
- `thr_lo` > `thr_hi` makes every check fail.
- Reset (any time, including mid-sweep):
  - `busy`, `sweep_done`, `ch_ok`, all stored counts, counter, timer and idx are 0; state is IDLE.
  - With the macro, `ch_fault` and `irq` are also 0.
  - `rd_count` reads 0.

## Timing
- Per channel: W (= latched `window`) MEASURE cycles, then 1 CHECK cycle, then 1 NEXT cycle, for W+2 cycles per channel.
- If `start` is sampled in IDLE at cycle 0:
  - The first MEASURE cycle is cycle 1.
  - For the last of K enabled channels, `sweep_done` is high in cycle K·(W+2).
  - `busy` rises in cycle 1 and falls in cycle K·(W+2)+1.
- `ch_ok[idx]` and count[idx] update on the clock edge ending CHECK, so they are visible in the NEXT cycle.
- Input-to-count latency is 3 clk cycles through the synchronizer. Edges arriving in the first 3 cycles after selection may belong to the previous window. The ±1 edge tolerance in the thresholds absorbs this.
- Toggle rate must stay below clk/2 for counts to be meaningful.

## Configuration
- Macro `XCVR_CLKMON_STICKY_EN`.
- With the macro defined:
  - `fault_clr`, `ch_fault` and `irq` exist.
  - A failing CHECK sets `ch_fault[idx]`, which stays set until `fault_clr`.
  - If set and clear occur in the same cycle, set wins.
  - `irq` = registered OR of `ch_fault`, one cycle after `ch_fault` changes.
- Without the macro: the three ports are absent, and `ch_ok` alone reflects the latest result.

## Test plan
- Single sweep, one channel: N_CH=4, `ch_en`=4'b0001, `window`=100, ch0 toggles every 4 clk, thresholds 24..26, `start` at cycle 0 → `rd_count`(sel 0) = 25 (±1), `ch_ok`[0]=1, `sweep_done` at cycle 102, `busy` high in cycles 1..102.
- Multi-channel: `ch_en`=4'b1011, `window`=50, toggles every 2/5/10 clk on ch0/1/3 → counts 25/10/5, ch2 skipped, `ch_ok`[2]=0, `sweep_done` at cycle 156.
- Dead clock and saturation:
  - ch1 held static → count 0, `ch_ok`[1]=0.
  - CNT_W=4, toggle every clk, window 40 → count 15.
- Start qualifiers:
  - `window`=0 or `ch_en`=0 with `start` → stays IDLE, no `sweep_done`.
  - `start` while busy → ignored, only one `sweep_done`.
- Continuous mode and reset:
  - `continuous`=1 → `sweep_done` pulses repeat every K·(W+2)+1 cycles.
  - `reset_n` low mid-MEASURE → all outputs 0 immediately; restart succeeds.
- With `XCVR_CLKMON_STICKY_EN`:
  - A failing channel sets `ch_fault` and `irq` one cycle later; both persist after a later passing sweep.
  - `fault_clr` clears them.
  - `fault_clr` in the same cycle as a failing CHECK → fault remains set.
